// File: rtl/sb_codex_pkg.sv
// Shared sideband definitions: header parity bit positions, TX scheduler state
// encoding and the header parity helper used by sb_tx_scheduler.
package sb_codex_pkg;

  localparam int SB_WORD_W     = 64;
  localparam int SB_HDR_CP_BIT = 62;
  localparam int SB_HDR_DP_BIT = 63;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2,
    GAP  = 2'd3
  } sb_tx_state_t;

  // cp covers header bits [61:0]; dp covers the payload only when one is sent.
  function automatic logic [SB_WORD_W-1:0] sb_hdr_with_parity(
    input logic [SB_WORD_W-1:0] hdr,
    input logic [SB_WORD_W-1:0] data,
    input logic                 has_data
  );
    logic [SB_WORD_W-1:0] h;
    h                = hdr;
    h[SB_HDR_CP_BIT] = ^hdr[SB_HDR_CP_BIT-1:0];
    h[SB_HDR_DP_BIT] = has_data ? ^data : 1'b0;
    return h;
  endfunction

endpackage

// File: rtl/sb_tx_scheduler_arb.sv
// Combinational round-robin arbiter: grants the first requester at or after
// ptr, wrapping around NUM_REQ.
module sb_rr_arbiter #(
  parameter int NUM_REQ   = 3,
  parameter int REQ_IDX_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]   req,
  input  logic [REQ_IDX_W-1:0] ptr,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [REQ_IDX_W-1:0] gnt_idx,
  output logic                 gnt_valid
);

  // Scan from the farthest offset to the nearest so the nearest hit wins.
  always_comb begin
    int idx;
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      idx = int'(ptr) + off;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req[idx]) begin
        gnt        = '0;
        gnt[idx]   = 1'b1;
        gnt_idx    = REQ_IDX_W'(idx);
        gnt_valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sb_tx_scheduler.sv
// Round-robin sideband TX scheduler: header beat, optional data beat, idle gap.
// Optional macro SB_TX_PARITY_EN overwrites header cp/dp bits at grant time.
module sb_tx_scheduler
  import sb_codex_pkg::*;
#(
  parameter int NUM_REQ    = 3,
  parameter int GAP_CYCLES = 4,
  parameter int REQ_IDX_W  = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*64-1:0]     req_hdr,
  input  logic [NUM_REQ*64-1:0]     req_data,
  input  logic [NUM_REQ-1:0]        req_has_data,
  output logic [NUM_REQ-1:0]        req_ack,
  output logic                      tx_valid,
  output logic [63:0]               tx_word,
  output logic                      tx_is_hdr,
  input  logic                      tx_ready,
  output logic                      busy,
  output logic [REQ_IDX_W-1:0]      grant_idx
);

  sb_tx_state_t         state_q, state_d;
  logic [REQ_IDX_W-1:0] ptr_q, ptr_d;
  logic [REQ_IDX_W-1:0] grant_idx_q, grant_idx_d;
  logic [NUM_REQ-1:0]   gnt_oh_q, gnt_oh_d;
  logic [NUM_REQ-1:0]   req_ack_q, req_ack_d;
  logic [63:0]          data_q, data_d;
  logic [63:0]          tx_word_q, tx_word_d;
  logic                 has_data_q, has_data_d;
  logic                 tx_valid_q, tx_valid_d;
  logic                 tx_is_hdr_q, tx_is_hdr_d;
  logic [3:0]           gap_cnt_q, gap_cnt_d;

  logic [NUM_REQ-1:0]   arb_gnt;
  logic [REQ_IDX_W-1:0] arb_idx;
  logic                 arb_valid;
  logic [63:0]          sel_hdr, sel_data, grant_hdr;
  logic                 sel_has_data;
  logic                 complete;

  sb_rr_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .REQ_IDX_W (REQ_IDX_W)
  ) u_arb (
    .req       (req_valid),
    .ptr       (ptr_q),
    .gnt       (arb_gnt),
    .gnt_idx   (arb_idx),
    .gnt_valid (arb_valid)
  );

  assign sel_hdr      = req_hdr[64*int'(arb_idx) +: 64];
  assign sel_data     = req_data[64*int'(arb_idx) +: 64];
  assign sel_has_data = req_has_data[arb_idx];

`ifdef SB_TX_PARITY_EN
  assign grant_hdr = sb_hdr_with_parity(sel_hdr, sel_data, sel_has_data);
`else
  assign grant_hdr = sel_hdr;
`endif

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_idx_d = grant_idx_q;
    gnt_oh_d    = gnt_oh_q;
    req_ack_d   = '0;
    data_d      = data_q;
    has_data_d  = has_data_q;
    tx_valid_d  = tx_valid_q;
    tx_word_d   = tx_word_q;
    tx_is_hdr_d = tx_is_hdr_q;
    gap_cnt_d   = gap_cnt_q;
    complete    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (arb_valid) begin
          grant_idx_d = arb_idx;
          gnt_oh_d    = arb_gnt;
          data_d      = sel_data;
          has_data_d  = sel_has_data;
          tx_valid_d  = 1'b1;
          tx_is_hdr_d = 1'b1;
          tx_word_d   = grant_hdr;
          state_d     = HDR;
        end
      end
      HDR: begin
        if (tx_ready) begin
          if (has_data_q) begin
            tx_word_d   = data_q;
            tx_is_hdr_d = 1'b0;
            state_d     = DATA;
          end else begin
            complete = 1'b1;
          end
        end
      end
      DATA: begin
        if (tx_ready) complete = 1'b1;
      end
      GAP: begin
        if (gap_cnt_q <= 4'd1) begin
          gap_cnt_d = '0;
          state_d   = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (complete) begin
      req_ack_d   = gnt_oh_q;
      ptr_d       = (grant_idx_q == REQ_IDX_W'(NUM_REQ - 1)) ? '0
                                                             : grant_idx_q + REQ_IDX_W'(1);
      tx_valid_d  = 1'b0;
      tx_is_hdr_d = 1'b0;
      tx_word_d   = '0;
      if (GAP_CYCLES == 0) begin
        state_d = IDLE;
      end else begin
        state_d   = GAP;
        gap_cnt_d = 4'(GAP_CYCLES);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      grant_idx_q <= '0;
      gnt_oh_q    <= '0;
      req_ack_q   <= '0;
      data_q      <= '0;
      has_data_q  <= 1'b0;
      tx_valid_q  <= 1'b0;
      tx_word_q   <= '0;
      tx_is_hdr_q <= 1'b0;
      gap_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_idx_q <= grant_idx_d;
      gnt_oh_q    <= gnt_oh_d;
      req_ack_q   <= req_ack_d;
      data_q      <= data_d;
      has_data_q  <= has_data_d;
      tx_valid_q  <= tx_valid_d;
      tx_word_q   <= tx_word_d;
      tx_is_hdr_q <= tx_is_hdr_d;
      gap_cnt_q   <= gap_cnt_d;
    end
  end

  assign req_ack   = req_ack_q;
  assign tx_valid  = tx_valid_q;
  assign tx_word   = tx_word_q;
  assign tx_is_hdr = tx_is_hdr_q;
  assign busy      = (state_q != IDLE);
  assign grant_idx = grant_idx_q;

endmodule

// File: tb/tb_sb_tx_scheduler.sv
// Randomized bench for sb_tx_scheduler against a transaction-level reference:
// a queue of expected beats, a round-robin pointer and an earliest-grant cycle.
module tb_sb_tx_scheduler;

  localparam int NUM_REQ    = 3;
  localparam int GAP_CYCLES = 4;
  localparam int REQ_IDX_W  = $clog2(NUM_REQ);
`ifdef SB_TX_PARITY_EN
  localparam bit PARITY_EN  = 1'b1;
`else
  localparam bit PARITY_EN  = 1'b0;
`endif

  logic                  clk;
  logic                  rst_n;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*64-1:0] req_hdr;
  logic [NUM_REQ*64-1:0] req_data;
  logic [NUM_REQ-1:0]    req_has_data;
  logic [NUM_REQ-1:0]    req_ack;
  logic                  tx_valid;
  logic [63:0]           tx_word;
  logic                  tx_is_hdr;
  logic                  tx_ready;
  logic                  busy;
  logic [REQ_IDX_W-1:0]  grant_idx;

  sb_tx_scheduler #(
    .NUM_REQ    (NUM_REQ),
    .GAP_CYCLES (GAP_CYCLES),
    .REQ_IDX_W  (REQ_IDX_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_hdr      (req_hdr),
    .req_data     (req_data),
    .req_has_data (req_has_data),
    .req_ack      (req_ack),
    .tx_valid     (tx_valid),
    .tx_word      (tx_word),
    .tx_is_hdr    (tx_is_hdr),
    .tx_ready     (tx_ready),
    .busy         (busy),
    .grant_idx    (grant_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] w;
    logic        is_hdr;
  } beat_t;

  beat_t exp_q[$];
  int    m_ptr, m_free_at, m_cur, m_gidx, cyc, pkt_cnt;
  int    gen_pct, ready_mode;
  bit    scramble;
  int    n_cmp, n_err;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [63:0] ref_hdr(input logic [63:0] h, input logic [63:0] d, input logic hd);
    logic [63:0] r;
    r = h;
    if (PARITY_EN) begin
      r[62] = ^h[61:0];
      r[63] = hd ? ^d : 1'b0;
    end
    return r;
  endfunction

  task automatic set_pkt(input int i, input logic [63:0] h, input logic [63:0] d, input logic hd);
    req_hdr[64*i +: 64]  = h;
    req_data[64*i +: 64] = d;
    req_has_data[i]      = hd;
    req_valid[i]         = 1'b1;
  endtask

  task automatic rand_pkt(input int i);
    logic [63:0] d;
    d = {$urandom, $urandom};
    if ($urandom_range(1) == 0) d[63:32] = '0;
    set_pkt(i, {$urandom, $urandom}, d, 1'($urandom_range(1)));
  endtask

  // One clock: predict from pre-edge inputs, compare after the edge, then drive.
  task automatic step();
    bit          do_grant, do_accept;
    int          g;
    logic [63:0] h, d;
    logic        hd;
    logic [NUM_REQ-1:0] exp_ack;
    do_accept = (exp_q.size() > 0) && tx_ready;
    do_grant  = (exp_q.size() == 0) && (cyc >= m_free_at) && (req_valid != '0);
    g = -1;
    for (int k = 0; k < NUM_REQ; k++) begin
      int c;
      c = (m_ptr + k) % NUM_REQ;
      if (g < 0 && req_valid[c]) g = c;
    end
    if (do_grant) begin
      h  = req_hdr[64*g +: 64];
      d  = req_data[64*g +: 64];
      hd = req_has_data[g];
    end
    @(posedge clk);
    exp_ack = '0;
    if (do_accept) begin
      void'(exp_q.pop_front());
      if (exp_q.size() == 0) begin
        exp_ack[m_cur] = 1'b1;
        m_ptr          = (m_cur + 1) % NUM_REQ;
        m_free_at      = cyc + 1 + GAP_CYCLES;
        pkt_cnt++;
        $display("pkt %0d: req %0d done at cycle %0d", pkt_cnt, m_cur, cyc);
      end
    end
    if (do_grant) begin
      exp_q.push_back('{w: ref_hdr(h, d, hd), is_hdr: 1'b1});
      if (hd) exp_q.push_back('{w: d, is_hdr: 1'b0});
      m_cur  = g;
      m_gidx = g;
    end
    #1;
    check_val("tx_valid", 64'(tx_valid), 64'(exp_q.size() > 0));
    if (exp_q.size() > 0) begin
      check_val("tx_word", tx_word, exp_q[0].w);
      check_val("tx_is_hdr", 64'(tx_is_hdr), 64'(exp_q[0].is_hdr));
    end
    check_val("req_ack", 64'(req_ack), 64'(exp_ack));
    check_val("busy", 64'(busy), 64'((exp_q.size() > 0) || (cyc < m_free_at - 1)));
    check_val("grant_idx", 64'(grant_idx), 64'(m_gidx));
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ack[i]) begin
        req_valid[i] = 1'b0;
      end else if (req_valid[i] && scramble && exp_q.size() > 0 && m_cur == i) begin
        rand_pkt(i);
      end else if (!req_valid[i] && $urandom_range(99) < gen_pct) begin
        rand_pkt(i);
      end
    end
    case (ready_mode)
      0:       tx_ready = 1'b1;
      1:       tx_ready = 1'($urandom_range(1));
      default: tx_ready = 1'b0;
    endcase
    cyc++;
  endtask

  initial begin
    bit found;
    n_cmp = 0; n_err = 0; cyc = 0; pkt_cnt = 0;
    m_ptr = 0; m_free_at = 0; m_cur = 0; m_gidx = 0;
    gen_pct = 0; ready_mode = 0; scramble = 1'b0;
    rst_n = 1'b0; req_valid = '0; req_hdr = '0; req_data = '0; req_has_data = '0;
    tx_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_tx_valid", 64'(tx_valid), 64'd0);
    check_val("rst_tx_word", tx_word, 64'd0);
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_ack", 64'(req_ack), 64'd0);
    check_val("rst_grant_idx", 64'(grant_idx), 64'd0);
    rst_n = 1'b1;
    tx_ready = 1'b1;

    // Single header-only packet on requester 0.
    set_pkt(0, 64'h0000_0000_0091_4012, 64'd0, 1'b0);
    repeat (10) step();

    // Header + data on requester 2.
    set_pkt(2, {$urandom, $urandom}, 64'hDEAD_BEEF_0000_0001, 1'b1);
    repeat (10) step();

    // All requesters continuously pending: strict round robin with gaps.
    gen_pct = 100;
    scramble = 1'b1;
    repeat (45) step();
    gen_pct = 0;
    repeat (30) step();

    // Backpressure on a header beat.
    ready_mode = 2;
    tx_ready = 1'b0;
    set_pkt(1, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
    repeat (7) step();
    ready_mode = 0;
    tx_ready = 1'b1;
    repeat (10) step();

    // Reset while the data beat is on the bus.
    set_pkt(2, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
    found = 1'b0;
    for (int k = 0; k < 12 && !found; k++) begin
      step();
      found = (exp_q.size() > 0) && !exp_q[0].is_hdr;
    end
    check_val("reach_data_beat", 64'(found), 64'd1);
    rst_n = 1'b0;
    #1;
    check_val("arst_tx_valid", 64'(tx_valid), 64'd0);
    check_val("arst_tx_word", tx_word, 64'd0);
    check_val("arst_busy", 64'(busy), 64'd0);
    check_val("arst_grant_idx", 64'(grant_idx), 64'd0);
    exp_q.delete();
    m_ptr = 0; m_gidx = 0;
    for (int i = 0; i < NUM_REQ; i++) rand_pkt(i);
    repeat (2) @(posedge clk);
    #1;
    check_val("arst_no_ack", 64'(req_ack), 64'd0);
    rst_n = 1'b1;
    m_free_at = cyc;
    repeat (30) step();

    // Random traffic with random backpressure.
    gen_pct = 30;
    ready_mode = 1;
    repeat (400) step();

`ifdef SB_TX_PARITY_EN
    gen_pct = 0;
    ready_mode = 0;
    tx_ready = 1'b1;
    scramble = 1'b0;
    repeat (40) step();
    set_pkt(0, 64'h1, 64'd0, 1'b0);
    found = 1'b0;
    for (int k = 0; k < 12 && !found; k++) begin
      step();
      found = (exp_q.size() > 0);
    end
    check_val("parity_reached", 64'(found), 64'd1);
    check_val("parity_word", tx_word, 64'h4000_0000_0000_0001);
`endif

    gen_pct = 0;
    ready_mode = 0;
    tx_ready = 1'b1;
    repeat (40) step();
    check_val("drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sb_tx_scheduler.md
Name: sb_tx_scheduler

Overview:
Shares the sideband transmit path between several requesters: LTSM state handlers, register-access completion logic and the management path.
- Each requester presents a pre-encoded 64-bit SB header, an optional 64-bit payload and a has_data flag.
- The block picks one requester by round-robin and emits the header word, then the data word if present, onto the 64-bit SB serializer interface.
- It then enforces a mandatory idle gap before the next packet.
- It sits between the SB message encode functions and the SB serializer.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- GAP_CYCLES, 4, idle cycles forced between packets (0..15).
- REQ_IDX_W, $clog2(NUM_REQ), width of the grant index.

Ports:
- clk  in  1  block clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester packet-pending flag.
- req_hdr  in  NUM_REQ*64  per-requester encoded header, slice i = [64*i+63:64*i].
- req_data  in  NUM_REQ*64  per-requester payload; 32b payloads are placed in [31:0] with [63:32] zero.
- req_has_data  in  NUM_REQ  1 = send a data beat after the header (expect_32b_data | expect_64b_data).
- req_ack  out  NUM_REQ  one-hot, single-cycle pulse when the granted packet has fully left.
- tx_valid  out  1  word valid to serializer.
- tx_word  out  64  header or data word.
- tx_is_hdr  out  1  1 = current word is a header.
- tx_ready  in  1  serializer accepts the word this cycle.
- busy  out  1  packet in flight or gap active.
- grant_idx  out  REQ_IDX_W  index of the current or last granted requester.

Behaviour:
- Reset (rst_n=0, async): state=IDLE, all outputs 0, round-robin pointer=0, gap counter=0, latched packet cleared.
- States: IDLE, HDR, DATA, GAP.
- IDLE:
  - If any req_valid is set, grant the first set bit at or after the pointer, wrapping.
  - Latch that requester's hdr, data and has_data into internal registers in the same cycle.
  - Go to HDR the next cycle.
  - Requester inputs are sampled only at grant; later changes do not affect the packet in flight.
- HDR:
  - tx_valid=1, tx_word=latched hdr, tx_is_hdr=1.
  - On tx_ready: go to DATA if has_data, else complete.
- DATA:
  - tx_valid=1, tx_word=latched data, tx_is_hdr=0.
  - On tx_ready: complete.
- Complete:
  - Pulse req_ack[grant_idx] for 1 cycle, in the cycle after the final accepted word.
  - Set pointer = grant_idx+1, wrapping NUM_REQ-1 -> 0.
  - Enter GAP with counter=GAP_CYCLES, or IDLE if GAP_CYCLES=0.
- GAP:
  - tx_valid=0; counter decrements each cycle.
  - At 1, go to IDLE.
  - req_valid is ignored during GAP.
- Valid/ready rule: tx_valid, once raised, holds and tx_word stays stable until tx_ready.
- Latency: grant-to-first-word is 1 cycle. Minimum packet period = 1 (arb) + beats + GAP_CYCLES.
- Requesters must drop req_valid in the cycle req_ack is seen. A requester still holding valid after its ack is treated as a new packet.
- Simultaneous requests are resolved strictly by round-robin; there is no priority inversion or starvation.
- busy = (state != IDLE).
- grant_idx holds its value in IDLE.
- Reset mid-packet aborts the packet immediately; no ack is issued.

Optional Feature:
- Macro SB_TX_PARITY_EN.
- Defined:
  - The latched header's bit 62 (cp) is overwritten with the XOR of hdr[61:0].
  - Bit 63 (dp) is overwritten with the XOR of data[63:0] when has_data, else 0.
  - Both are computed at grant time and registered, so latency is unchanged.
- Undefined: the header passes through unmodified.

Decomposition:
- Add to SB_codex_pkg:
  - SB_HDR_CP_BIT=62 and SB_HDR_DP_BIT=63 constants.
  - sb_tx_state_t enum {IDLE,HDR,DATA,GAP}.
- One sub-module, sb_rr_arbiter: inputs req vector and pointer; outputs one-hot grant and index; combinational.
- The FSM, latch registers and gap counter stay in the top module.

Test Plan:
- Single request, no data: req_valid=3'b001, hdr=64'h0000_0000_0091_4012, tx_ready=1.
  - Expect one word, tx_is_hdr=1, then req_ack=3'b001 the next cycle.
  - Expect tx_valid low for 4 cycles.
- Request with data on requester 2: has_data=1, data=64'hDEAD_BEEF_0000_0001.
  - Expect a header beat then a data beat, and req_ack=3'b100 after the second beat.
- All three requesting continuously: grant order is 0,1,2,0,…, each packet separated by exactly GAP_CYCLES idle cycles.
- Backpressure: tx_ready=0 for 5 cycles during HDR.
  - tx_word must stay stable and tx_valid must stay high.
  - Ack arrives only after acceptance.
- rst_n asserted low during DATA:
  - Outputs go to 0 asynchronously, no ack is issued, and the next grant starts at requester 0.
- With SB_TX_PARITY_EN: hdr=64'h1 with has_data=0 -> emitted word 64'h4000_0000_0000_0001.
